// File: rtl/regfile_pkg.sv
// Shared defaults and types for the scoreboarded register file.
package regfile_pkg;

   localparam int RF_DATA_W   = 16;
   localparam int RF_NUM_REGS = 16;
   localparam int RF_PEND_W   = 2;
   localparam int RF_ADDR_W   = $clog2(RF_NUM_REGS);

   typedef logic [RF_ADDR_W-1:0] reg_addr_t;
   typedef logic [RF_DATA_W-1:0] reg_data_t;

   localparam reg_addr_t ZERO_ADDR = '0;

endpackage

// File: rtl/rf_pend_ctr.sv
// Saturating pending-writer counter for one register: clr wins, inc+dec cancel,
// and an overflow/underflow attempt holds the count and raises sat_err for that cycle.
module rf_pend_ctr
   import regfile_pkg::*;
#(
   parameter int PEND_W = RF_PEND_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,
   input  logic              dec,
   input  logic              clr,
   output logic [PEND_W-1:0] cnt,
   output logic              full,
   output logic              sat_err
);

   localparam logic [PEND_W-1:0] CNT_MAX = '1;

   logic [PEND_W-1:0] cnt_reg;
   logic [PEND_W-1:0] cnt_next;

   always_comb begin
      cnt_next = cnt_reg;
      sat_err  = 1'b0;
      if (clr) begin
         cnt_next = '0;
      end else if (inc && !dec) begin
         if (cnt_reg == CNT_MAX) sat_err  = 1'b1;
         else                    cnt_next = cnt_reg + 1'b1;
      end else if (dec && !inc) begin
         if (cnt_reg == '0) sat_err  = 1'b1;
         else               cnt_next = cnt_reg - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_reg <= '0;
      else     cnt_reg <= cnt_next;
   end

   assign cnt  = cnt_reg;
   assign full = (cnt_reg == CNT_MAX);

endmodule

// File: rtl/regfile_sb.sv
// Register file with write-through bypass and per-register pending-write scoreboard.
// Optional even-parity protection is enabled by defining RF_PARITY_EN.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int NUM_REGS = RF_NUM_REGS,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int PEND_W   = RF_PEND_W,
   parameter int ZERO_REG = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_W-1:0]   rs1_addr,
   input  logic [ADDR_W-1:0]   rs2_addr,
   output logic [DATA_W-1:0]   rs1_data,
   output logic [DATA_W-1:0]   rs2_data,
   output logic                rs1_busy,
   output logic                rs2_busy,
   input  logic                rsv_valid,
   input  logic [ADDR_W-1:0]   rsv_addr,
   output logic                rsv_ready,
   input  logic                wb_valid,
   input  logic [ADDR_W-1:0]   wb_addr,
   input  logic [DATA_W-1:0]   wb_data,
   input  logic                flush,
   output logic [NUM_REGS-1:0] busy_vec,
   output logic                sb_err
`ifdef RF_PARITY_EN
   ,
   input  logic                par_inject,
   output logic                par_err
`endif
);

   logic [DATA_W-1:0]   mem_reg [NUM_REGS];
   logic [PEND_W-1:0]   pend    [NUM_REGS];
   logic [NUM_REGS-1:0] inc_vec;
   logic [NUM_REGS-1:0] dec_vec;
   logic [NUM_REGS-1:0] full_vec;
   logic [NUM_REGS-1:0] sat_vec;
   logic                sb_err_reg;

   logic rs1_zero, rs2_zero, rsv_zero, wb_zero;
   logic rs1_hit, rs2_hit, rsv_hit;
   logic [PEND_W-1:0] rs1_left, rs2_left;

   assign rs1_zero = (ZERO_REG != 0) && (rs1_addr == ADDR_W'(ZERO_ADDR));
   assign rs2_zero = (ZERO_REG != 0) && (rs2_addr == ADDR_W'(ZERO_ADDR));
   assign rsv_zero = (ZERO_REG != 0) && (rsv_addr == ADDR_W'(ZERO_ADDR));
   assign wb_zero  = (ZERO_REG != 0) && (wb_addr  == ADDR_W'(ZERO_ADDR));

   assign rs1_hit = wb_valid && (wb_addr == rs1_addr);
   assign rs2_hit = wb_valid && (wb_addr == rs2_addr);
   assign rsv_hit = wb_valid && (wb_addr == rsv_addr);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_pend
         localparam bit IS_ZERO = (ZERO_REG != 0) && (gi == 0);
         assign inc_vec[gi] = !IS_ZERO && rsv_valid && (rsv_addr == ADDR_W'(gi));
         assign dec_vec[gi] = !IS_ZERO && wb_valid  && (wb_addr  == ADDR_W'(gi));

         rf_pend_ctr #(.PEND_W(PEND_W)) u_ctr (
            .clk     (clk),
            .rst     (rst),
            .inc     (inc_vec[gi]),
            .dec     (dec_vec[gi]),
            .clr     (flush),
            .cnt     (pend[gi]),
            .full    (full_vec[gi]),
            .sat_err (sat_vec[gi])
         );

         assign busy_vec[gi] = (pend[gi] != '0);
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) mem_reg[i] <= '0;
      end else if (wb_valid && !wb_zero) begin
         mem_reg[wb_addr] <= wb_data;
      end
   end

   // Bypass first, then the zero register masks everything.
   always_comb begin
      rs1_data = rs1_hit ? wb_data : mem_reg[rs1_addr];
      rs2_data = rs2_hit ? wb_data : mem_reg[rs2_addr];
      if (rs1_zero) rs1_data = '0;
      if (rs2_zero) rs2_data = '0;
   end

   // A writeback landing this cycle retires one pending writer before the busy test.
   assign rs1_left  = pend[rs1_addr] - PEND_W'(rs1_hit);
   assign rs2_left  = pend[rs2_addr] - PEND_W'(rs2_hit);
   assign rs1_busy  = !rs1_zero && (rs1_left != '0);
   assign rs2_busy  = !rs2_zero && (rs2_left != '0);
   assign rsv_ready = rsv_zero || !full_vec[rsv_addr] || rsv_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           sb_err_reg <= 1'b0;
      else if (|sat_vec) sb_err_reg <= 1'b1;
   end

   assign sb_err = sb_err_reg;

`ifdef RF_PARITY_EN
   logic [NUM_REGS-1:0] par_reg;
   logic                par_err_reg;
   logic                rs1_par_bad, rs2_par_bad;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par_reg <= '0;
      end else if (wb_valid && !wb_zero) begin
         par_reg[wb_addr] <= (^wb_data) ^ par_inject;
      end
   end

   assign rs1_par_bad = !rs1_zero && !rs1_hit && ((^mem_reg[rs1_addr]) != par_reg[rs1_addr]);
   assign rs2_par_bad = !rs2_zero && !rs2_hit && ((^mem_reg[rs2_addr]) != par_reg[rs2_addr]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                             par_err_reg <= 1'b0;
      else if (rs1_par_bad || rs2_par_bad) par_err_reg <= 1'b1;
   end

   assign par_err = par_err_reg;
`endif

endmodule
